mas_alu_dispatch: RTL and testbench

Command dispatcher directly upstream of mas_alu_top. Buffers host ALU commands (cmd, op1, op2) in a FIFO and issues them one at a time over the ALU req/ready handshake. Captures each mas_alu_res and returns it in order on a valid/ready response port. Decouples the host from the ALU FSM latency.

---
 rtl/mas_alu_dispatch.sv | 166 ++++++++++++++++
 tb/tb_mas_alu_dispatch.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mas_alu_dispatch.sv
// Host-side command FIFO feeding mas_alu_top one command at a time, returning results in order.
// Optional build macro MAS_ALU_DISP_TIMEOUT_EN adds a WAIT watchdog that aborts with rsp_err.
`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

module mas_alu_dispatch #(
    parameter int BLEN    = `MAS_BLEN,
    parameter int CMD_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CMD_W-1:0]         cmd_op,
    input  logic [BLEN-1:0]          cmd_op1,
    input  logic [BLEN-1:0]          cmd_op2,
    output logic                     mas_alu_req,
    output logic [CMD_W-1:0]         mas_alu_cmd,
    output logic [BLEN-1:0]          mas_alu_op1,
    output logic [BLEN-1:0]          mas_alu_op2,
    input  logic                     mas_alu_ready,
    input  logic [BLEN-1:0]          mas_alu_res,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [BLEN-1:0]          rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = CMD_W + 2 * BLEN;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state_reg;
    logic [EW-1:0]     fifo_mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic              req_reg;
    logic [CMD_W-1:0]  cmd_reg;
    logic [BLEN-1:0]   op1_reg;
    logic [BLEN-1:0]   op2_reg;
    logic              rsp_valid_reg;
    logic [BLEN-1:0]   rsp_data_reg;

    assign cmd_ready = (count_reg < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // The response register is always empty in IDLE, so only occupancy gates the issue.
    assign pop       = (state_reg == ST_IDLE) && (count_reg != '0);
    assign head      = fifo_mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {cmd_op, cmd_op1, cmd_op2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

`ifdef MAS_ALU_DISP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_reg;
    logic          rsp_err_reg;
`else
    logic [31:0]   timeout_unused;
    assign timeout_unused = TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            req_reg       <= 1'b0;
            cmd_reg       <= '0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
`ifdef MAS_ALU_DISP_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        {cmd_reg, op1_reg, op2_reg} <= head;
                        req_reg   <= 1'b1;
                        state_reg <= ST_WAIT;
`ifdef MAS_ALU_DISP_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (mas_alu_ready) begin
                        rsp_data_reg  <= mas_alu_res;
                        rsp_valid_reg <= 1'b1;
                        req_reg       <= 1'b0;
                        state_reg     <= ST_RESP;
`ifdef MAS_ALU_DISP_TIMEOUT_EN
                        rsp_err_reg   <= 1'b0;
                    end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
                        // Limit reached with no result: abort this command with an error response.
                        rsp_data_reg  <= '0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        req_reg       <= 1'b0;
                        state_reg     <= ST_RESP;
                    end else begin
                        wait_cnt_reg  <= wait_cnt_reg + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mas_alu_req = req_reg;
    assign mas_alu_cmd = cmd_reg;
    assign mas_alu_op1 = op1_reg;
    assign mas_alu_op2 = op2_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign fifo_count  = count_reg;
`ifdef MAS_ALU_DISP_TIMEOUT_EN
    assign rsp_err     = rsp_err_reg;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mas_alu_dispatch.sv
// Scoreboard bench for mas_alu_dispatch with a behavioural ALU responder of programmable latency.
module tb_mas_alu_dispatch;
    localparam int BLEN  = 32;
    localparam int CMD_W = 4;
    localparam int DEPTH = 4;
    localparam logic [CMD_W-1:0] ADD = 4'h1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_op;
    logic [BLEN-1:0]  cmd_op1;
    logic [BLEN-1:0]  cmd_op2;
    logic             mas_alu_req;
    logic [CMD_W-1:0] mas_alu_cmd;
    logic [BLEN-1:0]  mas_alu_op1;
    logic [BLEN-1:0]  mas_alu_op2;
    logic             mas_alu_ready;
    logic [BLEN-1:0]  mas_alu_res;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [BLEN-1:0]  rsp_data;
    logic             rsp_err;
    logic [2:0]       fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int alu_lat = 0;
    bit alu_never = 0;
    logic [BLEN:0] exp_q [$];
    int rise_q [$];

    mas_alu_dispatch #(.BLEN(BLEN), .CMD_W(CMD_W), .DEPTH(DEPTH), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .mas_alu_req(mas_alu_req), .mas_alu_cmd(mas_alu_cmd),
        .mas_alu_op1(mas_alu_op1), .mas_alu_op2(mas_alu_op2),
        .mas_alu_ready(mas_alu_ready), .mas_alu_res(mas_alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU responder: acts on the falling edge, ready after alu_lat req cycles.
    initial begin : alu_model
        bit prev_req;
        int busy;
        logic [BLEN-1:0] rec_op1, rec_op2;
        prev_req = 0;
        busy = 0;
        mas_alu_ready = 1'b0;
        mas_alu_res = '0;
        forever begin
            @(negedge clk);
            mas_alu_ready = 1'b0;
            if (mas_alu_req === 1'b1) begin
                if (!prev_req) begin
                    busy = 0;
                    rec_op1 = mas_alu_op1;
                    rec_op2 = mas_alu_op2;
                    rise_q.push_back(cyc);
                end else begin
                    checks++;
                    if ({mas_alu_op1, mas_alu_op2} !== {rec_op1, rec_op2}) begin
                        errors++;
                        $display("FAIL op_stable got %h/%h want %h/%h", mas_alu_op1, mas_alu_op2, rec_op1, rec_op2);
                    end
                end
                if (!alu_never && busy == alu_lat) begin
                    mas_alu_ready = 1'b1;
                    mas_alu_res = mas_alu_op1 + mas_alu_op2;
                end
                busy++;
            end
            prev_req = (mas_alu_req === 1'b1);
        end
    end

    // Response scoreboard: compares on each accepted response.
    initial begin : rsp_monitor
        logic [BLEN:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got err=%0b data=%0d", rsp_err, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_err, rsp_data} !== e) begin
                        errors++;
                        $display("FAIL rsp_data got err=%0b data=%0d want err=%0b data=%0d",
                                 rsp_err, rsp_data, e[BLEN], e[BLEN-1:0]);
                    end else
                        $display("RSP cyc=%0d err=%0b data=%0d", cyc, rsp_err, rsp_data);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "timeout");
    end

    task automatic push_cmd(input logic [CMD_W-1:0] op, input logic [BLEN-1:0] a, input logic [BLEN-1:0] b,
                            input bit exp_err, input int budget, output bit ok);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_op1 = a;
        cmd_op2 = b;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (ok) begin
            exp_q.push_back(exp_err ? {1'b1, {BLEN{1'b0}}} : {1'b0, a + b});
            $display("CMD cyc=%0d op=%0d op1=%0d op2=%0d", cyc, op, a, b);
        end
    endtask

    task automatic push_ok(input logic [BLEN-1:0] a, input logic [BLEN-1:0] b);
        bit ok;
        push_cmd(ADD, a, b, 1'b0, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_stall got cmd_ready=0 want accept op1=%0d", a);
        end
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || rsp_valid) && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        checks++;
        if (i >= budget) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_op1 = '0;
        cmd_op2 = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mas_alu_req, mas_alu_cmd, mas_alu_op1, mas_alu_op2, rsp_valid, rsp_data, rsp_err, fifo_count, cmd_ready}
            !== {1'b0, {CMD_W{1'b0}}, {BLEN{1'b0}}, {BLEN{1'b0}}, 1'b0, {BLEN{1'b0}}, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got req=%0b rv=%0b cnt=%0d rdy=%0b want 0/0/0/1",
                     mas_alu_req, rsp_valid, fifo_count, cmd_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_add;
        bit ok;
        alu_lat = 3;
        rsp_ready = 1'b0;
        push_cmd(ADD, 5, 7, 1'b0, 5, ok);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({mas_alu_req, mas_alu_cmd, mas_alu_op1, mas_alu_op2, rsp_valid} !== {1'b1, ADD, 32'd5, 32'd7, 1'b0}) begin
                errors++;
                $display("FAIL add_req cycle %0d got req=%0b cmd=%0d ops=%0d/%0d rv=%0b want 1/%0d/5/7/0",
                         i, mas_alu_req, mas_alu_cmd, mas_alu_op1, mas_alu_op2, rsp_valid, ADD);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_data, mas_alu_req} !== {1'b1, 32'd12, 1'b0}) begin
            errors++;
            $display("FAIL add_rsp got rv=%0b data=%0d req=%0b want 1/12/0", rsp_valid, rsp_data, mas_alu_req);
        end
        rsp_ready = 1'b1;
        wait_drain(10);
    endtask

    task automatic test_fill_backpressure;
        bit ok;
        alu_lat = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_ok(BLEN'(10 * i + 1), BLEN'(3 * i));
        checks++;
        if ({fifo_count, cmd_ready} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fill_count got cnt=%0d rdy=%0b want 4/0", fifo_count, cmd_ready);
        end
        push_cmd(ADD, 99, 1, 1'b0, 3, ok);
        checks++;
        if (ok) begin
            errors++;
            $display("FAIL full_push got accepted want stalled");
        end
        rsp_ready = 1'b1;
        wait_drain(100);
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL fill_empty got cnt=%0d want 0", fifo_count);
        end
    endtask

    task automatic test_back_to_back;
        alu_lat = 0;
        rsp_ready = 1'b1;
        rise_q.delete();
        for (int i = 1; i <= 4; i++) push_ok(BLEN'(i), BLEN'(i));
        wait_drain(60);
        checks++;
        if (rise_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d reqs want 4", rise_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (rise_q[i] - rise_q[i-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_period got %0d cycles want 3", rise_q[i] - rise_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_simul_push_pop;
        alu_lat = 0;
        rsp_ready = 1'b0;
        push_ok(100, 1);
        push_ok(200, 2);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL sim_pre got cnt=%0d want 1", fifo_count);
        end
        // Handshake while pushing: count rises to 2, then next cycle pops and pushes together.
        cmd_valid = 1'b1; cmd_op = ADD; cmd_op1 = 300; cmd_op2 = 3;
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 32'd303});
        @(posedge clk);
        #1;
        checks++;
        if (fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL sim_fill got cnt=%0d want 2", fifo_count);
        end
        rsp_ready = 1'b0;
        cmd_op1 = 400; cmd_op2 = 4;
        exp_q.push_back({1'b0, 32'd404});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if ({fifo_count, mas_alu_req} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL sim_push_pop got cnt=%0d req=%0b want 2/1", fifo_count, mas_alu_req);
        end
        rsp_ready = 1'b1;
        for (int i = 5; i <= 10; i++) push_ok(BLEN'(i * 1000), BLEN'(i));
        wait_drain(100);
    endtask

    task automatic test_reset_midflight;
        alu_never = 1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_ok(BLEN'(50 + i), 1);
        checks++;
        if ({fifo_count, mas_alu_req} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre got cnt=%0d req=%0b want 3/1", fifo_count, mas_alu_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mas_alu_req, mas_alu_cmd, mas_alu_op1, mas_alu_op2, rsp_valid, rsp_data, rsp_err, fifo_count, cmd_ready}
            !== {1'b0, {CMD_W{1'b0}}, {BLEN{1'b0}}, {BLEN{1'b0}}, 1'b0, {BLEN{1'b0}}, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset got req=%0b op1=%0d cnt=%0d rdy=%0b want 0/0/0/1",
                     mas_alu_req, mas_alu_op1, fifo_count, cmd_ready);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        alu_never = 0;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                if (rsp_valid || mas_alu_req) seen = 1;
            end
            checks++;
            if (seen) begin
                errors++;
                $display("FAIL mid_after got activity after reset want none");
            end
        end
    endtask

`ifdef MAS_ALU_DISP_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        alu_never = 1;
        rsp_ready = 1'b0;
        push_cmd(ADD, 77, 1, 1'b1, 5, ok);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({mas_alu_req, rsp_valid} !== 2'b10) begin
                errors++;
                $display("FAIL to_wait cycle %0d got req=%0b rv=%0b want 1/0", i, mas_alu_req, rsp_valid);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_data, mas_alu_req} !== {1'b1, 1'b1, {BLEN{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL to_rsp got rv=%0b err=%0b data=%0d req=%0b want 1/1/0/0",
                     rsp_valid, rsp_err, rsp_data, mas_alu_req);
        end
        alu_never = 0;
        alu_lat = 1;
        rsp_ready = 1'b1;
        push_ok(8, 9);
        wait_drain(40);
    endtask
`endif

    initial begin
        test_reset;
        test_single_add;
        test_fill_backpressure;
        test_back_to_back;
        test_simul_push_pop;
`ifdef MAS_ALU_DISP_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_midflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
